// File: rtl/dus_ctrl.sv
// rtl/dus_ctrl.sv - frame load, dus_hls kernel sequencing, result drain and BRAM arbitration
module dus_ctrl #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int IMG_WORDS = 1024,
    parameter int OUT_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_start,
    output logic              busy,
    output logic              frame_done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              k_ap_start,
    input  logic              k_ap_done,
    input  logic              k_ap_ready,
    input  logic              k_ap_idle,
    input  logic [ADDR_W-1:0] k_img_address0,
    input  logic              k_img_ce0,
    input  logic              k_img_we0,
    input  logic [DATA_W-1:0] k_img_d0,
    output logic [DATA_W-1:0] k_img_q0,
    input  logic [ADDR_W-1:0] k_dus_address0,
    input  logic              k_dus_ce0,
    input  logic              k_dus_we0,
    input  logic [DATA_W-1:0] k_dus_d0,
    output logic [DATA_W-1:0] k_dus_q0,
    output logic [ADDR_W-1:0] img_address0,
    output logic              img_ce0,
    output logic              img_we0,
    output logic [DATA_W-1:0] img_d0,
    input  logic [DATA_W-1:0] img_q0,
    output logic [ADDR_W-1:0] dus_address0,
    output logic              dus_ce0,
    output logic              dus_we0,
    output logic [DATA_W-1:0] dus_d0,
    input  logic [DATA_W-1:0] dus_q0
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // Counters carry one extra bit so a full 2^ADDR_W count does not wrap.
    localparam logic [ADDR_W:0] IMG_LAST = (ADDR_W+1)'(IMG_WORDS - 1);
    localparam logic [ADDR_W:0] OUT_LAST = (ADDR_W+1)'(OUT_WORDS - 1);
    localparam logic [ADDR_W:0] OUT_NUM  = (ADDR_W+1)'(OUT_WORDS);

    state_t            state;
    state_t            state_nx;

    logic [ADDR_W:0]   load_cnt;
    logic [ADDR_W:0]   rd_addr;
    logic [ADDR_W:0]   out_cnt;
    logic [DATA_W-1:0] fifo_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        occ;
    logic              inflight;
    logic [1:0]        level;
    logic              load_fire;
    logic              pop;
    logic              rd_en;

    // k_ap_idle is informational only; it never steers the sequencer.
    logic              unused_status;
    assign unused_status = k_ap_idle;

    assign load_fire = (state == S_LOAD) && in_valid;
    assign pop       = out_valid && out_ready;
    assign level     = occ + {1'b0, inflight};

    // A word leaving the FIFO this cycle frees a slot for the read issued now,
    // which is what lets an unstalled drain sustain one word per cycle.
    assign rd_en = (state == S_DRAIN) && (rd_addr < OUT_NUM) &&
                   (pop ? (level <= 2'd2) : (level < 2'd2));

    assign out_data = fifo_mem[rd_ptr];
    assign k_img_q0 = img_q0;
    assign k_dus_q0 = dus_q0;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (cmd_start) state_nx = S_LOAD;
            S_LOAD:  if (load_fire && (load_cnt == IMG_LAST)) state_nx = S_START;
            S_START: if (k_ap_ready) state_nx = k_ap_done ? S_DRAIN : S_RUN;
            S_RUN:   if (k_ap_done) state_nx = S_DRAIN;
            S_DRAIN: if (pop && (out_cnt == OUT_LAST)) state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Status and handshake outputs decoded from the registered state
    always_comb begin
        busy       = (state != S_IDLE);
        frame_done = (state == S_DONE);
        in_ready   = (state == S_LOAD);
        k_ap_start = (state == S_START);
        out_valid  = (state == S_DRAIN) && (occ != 2'd0);
    end

    // Load counter, drain read address, in-flight flag and FIFO bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            load_cnt <= '0;
            rd_addr  <= '0;
            out_cnt  <= '0;
            occ      <= '0;
            inflight <= 1'b0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
        end else begin
            if (state == S_IDLE) begin
                load_cnt <= '0;
            end else if (load_fire) begin
                load_cnt <= load_cnt + 1'b1;
            end

            if (state != S_DRAIN) begin
                rd_addr  <= '0;
                out_cnt  <= '0;
                occ      <= '0;
                inflight <= 1'b0;
                wr_ptr   <= 1'b0;
                rd_ptr   <= 1'b0;
            end else begin
                inflight <= rd_en;
                if (rd_en) rd_addr <= rd_addr + 1'b1;
                if (inflight) wr_ptr <= ~wr_ptr;
                if (pop) begin
                    rd_ptr  <= ~rd_ptr;
                    out_cnt <= out_cnt + 1'b1;
                end
                case ({inflight, pop})
                    2'b10:   occ <= occ + 2'd1;
                    2'b01:   occ <= occ - 2'd1;
                    default: occ <= occ;
                endcase
            end
        end
    end

    // Capture dus read data one cycle after the read was issued
    always_ff @(posedge clk) begin
        if ((state == S_DRAIN) && inflight) begin
            fifo_mem[wr_ptr] <= dus_q0;
        end
    end

    // BRAM ownership: kernel in START/RUN, controller otherwise
    always_comb begin
        img_address0 = '0;
        img_ce0      = 1'b0;
        img_we0      = 1'b0;
        img_d0       = '0;
        dus_address0 = '0;
        dus_ce0      = 1'b0;
        dus_we0      = 1'b0;
        dus_d0       = '0;
        case (state)
            S_START, S_RUN: begin
                img_address0 = k_img_address0;
                img_ce0      = k_img_ce0;
                img_we0      = k_img_we0;
                img_d0       = k_img_d0;
                dus_address0 = k_dus_address0;
                dus_ce0      = k_dus_ce0;
                dus_we0      = k_dus_we0;
                dus_d0       = k_dus_d0;
            end
            S_LOAD: begin
                if (load_fire) begin
                    img_address0 = load_cnt[ADDR_W-1:0];
                    img_ce0      = 1'b1;
                    img_we0      = 1'b1;
                    img_d0       = in_data;
                end
            end
            S_DRAIN: begin
                if (rd_en) begin
                    dus_address0 = rd_addr[ADDR_W-1:0];
                    dus_ce0      = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_dus_ctrl.sv
// tb/tb_dus_ctrl.sv - directed self-checking bench for dus_ctrl
`timescale 1ns/1ps

`define CHECK(tag, obs, exp) \
    begin \
        tests++; \
        assert ((obs) === (exp)) else begin \
            fails++; \
            $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
        end \
    end

module tb_dus_ctrl;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int IMG_N = 1024;
    localparam int OUT_N = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_start;
    logic          busy;
    logic          frame_done;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          k_ap_start;
    logic          k_ap_done;
    logic          k_ap_ready;
    logic          k_ap_idle;
    logic [AW-1:0] k_img_address0;
    logic          k_img_ce0;
    logic          k_img_we0;
    logic [DW-1:0] k_img_d0;
    logic [DW-1:0] k_img_q0;
    logic [AW-1:0] k_dus_address0;
    logic          k_dus_ce0;
    logic          k_dus_we0;
    logic [DW-1:0] k_dus_d0;
    logic [DW-1:0] k_dus_q0;
    logic [AW-1:0] img_address0;
    logic          img_ce0;
    logic          img_we0;
    logic [DW-1:0] img_d0;
    logic [DW-1:0] img_q0;
    logic [AW-1:0] dus_address0;
    logic          dus_ce0;
    logic          dus_we0;
    logic [DW-1:0] dus_d0;
    logic [DW-1:0] dus_q0;

    logic          clr_img = 1'b0;
    logic          clr_dus = 1'b0;
    logic [DW-1:0] img_mem [0:(1<<AW)-1];
    logic [DW-1:0] dus_mem [0:(1<<AW)-1];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dus_ctrl #(
        .ADDR_W(AW), .DATA_W(DW), .IMG_WORDS(IMG_N), .OUT_WORDS(OUT_N)
    ) dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .busy(busy), .frame_done(frame_done),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .k_ap_start(k_ap_start), .k_ap_done(k_ap_done), .k_ap_ready(k_ap_ready), .k_ap_idle(k_ap_idle),
        .k_img_address0(k_img_address0), .k_img_ce0(k_img_ce0), .k_img_we0(k_img_we0),
        .k_img_d0(k_img_d0), .k_img_q0(k_img_q0),
        .k_dus_address0(k_dus_address0), .k_dus_ce0(k_dus_ce0), .k_dus_we0(k_dus_we0),
        .k_dus_d0(k_dus_d0), .k_dus_q0(k_dus_q0),
        .img_address0(img_address0), .img_ce0(img_ce0), .img_we0(img_we0),
        .img_d0(img_d0), .img_q0(img_q0),
        .dus_address0(dus_address0), .dus_ce0(dus_ce0), .dus_we0(dus_we0),
        .dus_d0(dus_d0), .dus_q0(dus_q0)
    );

    // Single-port BRAM models with one-cycle read latency
    always @(posedge clk) begin
        if (clr_img) begin
            for (int i = 0; i < (1<<AW); i++) img_mem[i] <= '1;
        end else if (img_ce0) begin
            if (img_we0) img_mem[img_address0] <= img_d0;
            img_q0 <= img_mem[img_address0];
        end
        if (clr_dus) begin
            for (int i = 0; i < (1<<AW); i++) dus_mem[i] <= '1;
        end else if (dus_ce0) begin
            if (dus_we0) dus_mem[dus_address0] <= dus_d0;
            dus_q0 <= dus_mem[dus_address0];
        end
    end

    task automatic kernel_quiet();
        k_img_address0 = '0; k_img_ce0 = 1'b0; k_img_we0 = 1'b0; k_img_d0 = '0;
        k_dus_address0 = '0; k_dus_ce0 = 1'b0; k_dus_we0 = 1'b0; k_dus_d0 = '0;
    endtask

    task automatic start_frame(input bit clear_dus);
        clr_img   = 1'b1;
        clr_dus   = clear_dus;
        cmd_start = 1'b1;
        #1;
        `CHECK("idle_busy_before_start", busy, 1'b0)
        @(negedge clk);
        clr_img   = 1'b0;
        clr_dus   = 1'b0;
        cmd_start = 1'b0;
    endtask

    task automatic load_frame(input bit gaps, input int exp_cycles);
        int idx = 0;
        int cyc = 0;
        int bad = 0;
        k_img_ce0 = 1'b1; k_img_we0 = 1'b1; k_img_address0 = '1; k_img_d0 = 32'hDEAD_BEEF;
        while (idx < IMG_N && cyc < 4000) begin
            in_valid = !(gaps && (cyc % 3 == 0));
            in_data  = DW'(idx);
            #1;
            if (in_ready !== 1'b1 || k_img_q0 !== img_q0) bad++;
            if (in_valid) begin
                if (img_ce0 !== 1'b1 || img_we0 !== 1'b1 ||
                    img_address0 !== AW'(idx) || img_d0 !== DW'(idx)) bad++;
                idx++;
            end else if (img_ce0 !== 1'b0) begin
                bad++;
            end
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        kernel_quiet();
        `CHECK("load_cycles", cyc, exp_cycles)
        `CHECK("load_protocol_errs", bad, 0)
        bad = 0;
        for (int i = 0; i < IMG_N; i++) if (img_mem[i] !== DW'(i)) bad++;
        `CHECK("img_contents_errs", bad, 0)
    endtask

    task automatic kernel_phase(input bit together, input int abort_at);
        int bad = 0;
        in_valid  = 1'b1;
        cmd_start = 1'b1;
        #1;
        `CHECK("start_first_cycle", k_ap_start, 1'b1)
        `CHECK("start_in_ready_low", in_ready, 1'b0)
        @(negedge clk);
        in_valid = 1'b0; cmd_start = 1'b0;
        #1;
        `CHECK("start_held", k_ap_start, 1'b1)
        @(negedge clk);
        k_ap_ready = 1'b1; k_ap_done = together;
        #1;
        `CHECK("start_at_ready", k_ap_start, 1'b1)
        @(negedge clk);
        k_ap_ready = 1'b0; k_ap_done = 1'b0;
        #1;
        `CHECK("start_dropped_after_ready", k_ap_start, 1'b0)
        `CHECK("busy_after_start", busy, 1'b1)
        if (together) return;
        for (int r = 0; r < OUT_N; r++) begin
            k_dus_ce0 = 1'b1; k_dus_we0 = 1'b1;
            k_dus_address0 = AW'(r); k_dus_d0 = DW'(3 * r);
            k_img_ce0 = 1'b1; k_img_we0 = 1'b0; k_img_address0 = 10'h155;
            #1;
            if (dus_ce0 !== 1'b1 || dus_we0 !== 1'b1 ||
                dus_address0 !== AW'(r) || dus_d0 !== DW'(3 * r)) bad++;
            if (r == 0) begin
                `CHECK("run_img_addr_passthru", img_address0, 10'h155)
                `CHECK("run_img_ce_passthru", img_ce0, 1'b1)
            end
            if (r == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                #1;
                `CHECK("abort_busy", busy, 1'b0)
                `CHECK("abort_ap_start", k_ap_start, 1'b0)
                `CHECK("abort_img_ce_ignored", img_ce0, 1'b0)
                `CHECK("abort_in_ready", in_ready, 1'b0)
                kernel_quiet();
                return;
            end
            @(negedge clk);
        end
        `CHECK("run_dus_write_errs", bad, 0)
        kernel_quiet();
        k_ap_done = 1'b1;
        #1;
        `CHECK("run_ap_start_low", k_ap_start, 1'b0)
        @(negedge clk);
        k_ap_done = 1'b0;
    endtask

    task automatic drain_frame(input bit bp);
        int d = 0;
        int got = 0;
        int first_v = -1;
        int last_hs = -1;
        int bad = 0;
        int stall_bad = 0;
        logic held = 1'b0;
        logic [DW-1:0] held_data = '0;
        k_img_ce0 = 1'b1; k_img_we0 = 1'b1;
        k_dus_ce0 = 1'b1; k_dus_we0 = 1'b1; k_dus_address0 = '0; k_dus_d0 = '1;
        while (got < OUT_N && d < 3000) begin
            out_ready = bp ? ((d % 4 == 0) || (d % 4 == 3)) : 1'b1;
            #1;
            if (img_ce0 !== 1'b0 || dus_we0 !== 1'b0 ||
                k_dus_q0 !== dus_q0 || frame_done !== 1'b0) bad++;
            if (out_valid === 1'b1) begin
                if (first_v < 0) first_v = d;
                if (held && out_data !== held_data) stall_bad++;
                if (out_data !== DW'(3 * got)) bad++;
                if (out_ready) begin
                    got++;
                    last_hs = d;
                end
            end
            held      = (out_valid === 1'b1) && !out_ready;
            held_data = out_data;
            d++;
            @(negedge clk);
        end
        kernel_quiet();
        `CHECK("drain_words", got, OUT_N)
        `CHECK("drain_first_valid_cycle", first_v, 2)
        `CHECK("drain_data_errs", bad, 0)
        `CHECK("drain_stall_stability_errs", stall_bad, 0)
        if (!bp) `CHECK("drain_last_handshake_cycle", last_hs, OUT_N + 1)
        cmd_start = 1'b1;
        #1;
        `CHECK("done_pulse", frame_done, 1'b1)
        `CHECK("done_busy", busy, 1'b1)
        `CHECK("done_out_valid", out_valid, 1'b0)
        @(negedge clk);
        cmd_start = 1'b0;
        #1;
        `CHECK("post_done_pulse_low", frame_done, 1'b0)
        `CHECK("post_done_busy_low", busy, 1'b0)
        `CHECK("post_done_start_ignored", in_ready, 1'b0)
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cmd_start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        k_ap_done = 1'b0; k_ap_ready = 1'b0; k_ap_idle = 1'b1;
        kernel_quiet();

        repeat (3) @(negedge clk);
        #1;
        `CHECK("rst_busy", busy, 1'b0)
        `CHECK("rst_frame_done", frame_done, 1'b0)
        `CHECK("rst_in_ready", in_ready, 1'b0)
        `CHECK("rst_out_valid", out_valid, 1'b0)
        `CHECK("rst_ap_start", k_ap_start, 1'b0)
        rst = 1'b0;
        k_img_ce0 = 1'b1; k_img_we0 = 1'b1; k_img_address0 = 10'h155; k_img_d0 = '1;
        k_dus_ce0 = 1'b1; k_dus_we0 = 1'b1; k_dus_address0 = 10'h2AA; k_dus_d0 = '1;
        #1;
        `CHECK("idle_img_ce", img_ce0, 1'b0)
        `CHECK("idle_img_we", img_we0, 1'b0)
        `CHECK("idle_img_addr", img_address0, 10'h000)
        `CHECK("idle_img_d", img_d0, 32'h0)
        `CHECK("idle_dus_ce", dus_ce0, 1'b0)
        `CHECK("idle_dus_we", dus_we0, 1'b0)
        `CHECK("idle_dus_addr", dus_address0, 10'h000)
        kernel_quiet();

        start_frame(1'b1); load_frame(1'b0, IMG_N); kernel_phase(1'b0, -1); drain_frame(1'b0);
        start_frame(1'b1); load_frame(1'b0, IMG_N); kernel_phase(1'b0, -1); drain_frame(1'b1);
        start_frame(1'b1); load_frame(1'b1, 1536);  kernel_phase(1'b0, -1); drain_frame(1'b0);
        start_frame(1'b1); load_frame(1'b0, IMG_N); kernel_phase(1'b0, 10);
        start_frame(1'b1); load_frame(1'b0, IMG_N); kernel_phase(1'b0, -1); drain_frame(1'b0);
        start_frame(1'b0); load_frame(1'b0, IMG_N); kernel_phase(1'b1, -1); drain_frame(1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
